// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the access-legality decode used by the top level.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } lsu_state_e;

    // Misalignment, range, illegal encoding, or a store using an unsigned width.
    function automatic logic decode_fault(
        input logic [2:0] funct3,
        input logic       is_store,
        input logic [1:0] byte_off,
        input logic       out_of_range
    );
        logic f;
        f = out_of_range;
        case (funct3)
            F3_B:    f = f;
            F3_H:    f = f | byte_off[0];
            F3_W:    f = f | (byte_off != 2'b00);
            F3_BU:   f = f | is_store;
            F3_HU:   f = f | is_store | byte_off[0];
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load bytes and halves, and
// merges store bytes/halves into the current memory word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  byte_off_i,
    input  logic [31:0] mem_word_i,
    input  logic [15:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_word_o
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = mem_word_i[{byte_off_i, 3'b000} +: 8];
    assign sel_half = mem_word_i[{byte_off_i[1], 4'b0000} +: 16];

    always_comb begin
        load_data_o = mem_word_i;
        case (funct3_i)
            F3_B:    load_data_o = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    load_data_o = {{16{sel_half[15]}}, sel_half};
            F3_BU:   load_data_o = {24'h0, sel_byte};
            F3_HU:   load_data_o = {16'h0, sel_half};
            default: load_data_o = mem_word_i;
        endcase
    end

    // funct3[0] separates halfword stores from byte stores on the merge path.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic       lane_en;
        logic [7:0] lane_data;
        assign lane_en   = funct3_i[0] ? (byte_off_i[1] == 1'(gi / 2))
                                       : (byte_off_i == 2'(gi));
        assign lane_data = funct3_i[0] ? store_data_i[8*(gi%2) +: 8]
                                       : store_data_i[7:0];
        assign merged_word_o[8*gi +: 8] = lane_en ? lane_data : mem_word_i[8*gi +: 8];
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-cycle loads and word stores, read-modify-write
// for byte/halfword stores over a word-wide combinational-read memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        fault,
    output logic [31:0] mem_address,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic [29:0] idx_q, idx_d;
    logic [31:0] merged_q, merged_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic        out_of_range;
    logic        acc_fault;
    logic        mem_write_raw;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign out_of_range = {1'b0, addr[31:2]} >= 31'(ADDR_WORDS);
    assign acc_fault    = decode_fault(funct3, req_write, addr[1:0], out_of_range);

    lsu_align u_align (
        .funct3_i      (funct3),
        .byte_off_i    (addr[1:0]),
        .mem_word_i    (mem_rdata),
        .store_data_i  (wdata[15:0]),
        .load_data_o   (load_data),
        .merged_word_o (merged_word)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        merged_d      = merged_q;
        resp_valid_d  = 1'b0;
        rdata_d       = rdata_q;
        fault_d       = fault_q;
        mem_write_raw = 1'b0;
        mem_wdata     = wdata;
        mem_address   = {2'b00, addr[31:2]};
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (acc_fault) begin
                        resp_valid_d = 1'b1;
                        rdata_d      = 32'h0;
                        fault_d      = 1'b1;
                    end else if (!req_write) begin
                        resp_valid_d = 1'b1;
                        rdata_d      = load_data;
                        fault_d      = 1'b0;
                    end else if (funct3 == F3_W) begin
                        mem_write_raw = 1'b1;
                        resp_valid_d  = 1'b1;
                        rdata_d       = 32'h0;
                        fault_d       = 1'b0;
                    end else begin
                        merged_d = merged_word;
                        idx_d    = addr[31:2];
                        state_d  = ST_RMW;
                    end
                end
            end
            ST_RMW: begin
                mem_address   = {2'b00, idx_q};
                mem_write_raw = 1'b1;
                mem_wdata     = merged_q;
                state_d       = ST_IDLE;
                resp_valid_d  = 1'b1;
                rdata_d       = 32'h0;
                fault_d       = 1'b0;
            end
        endcase
    end

    // The accept-cycle write path is combinational, so reset must mask it directly.
    assign mem_write  = mem_write_raw & ~reset;
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign fault      = fault_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= 30'h0;
            merged_q     <= 32'h0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            merged_q     <= merged_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            fault_q      <= fault_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed accesses against a byte-level reference
// memory model checked every cycle, plus literal expectations per scenario.
module tb_load_store_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        fault;
    logic [31:0] mem_address;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] tb_mem  [0:1023];
    logic [31:0] ref_mem [0:1023];

    int wr_count = 0;
    int last_wr_idx = -1;

    load_store_unit #(.ADDR_WORDS(1024)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .rdata       (rdata),
        .fault       (fault),
        .mem_address (mem_address),
        .mem_write   (mem_write),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_rdata = (mem_address < 32'd1024) ? tb_mem[mem_address[9:0]] : 32'h0;

    always @(posedge clock) begin
        if (mem_write && mem_address < 32'd1024)
            tb_mem[mem_address[9:0]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_fault(input logic wr, input logic [2:0] f, input logic [31:0] a);
        logic legal;
        logic bad;
        legal = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
        bad = !legal;
        if ((f == 3'd1 || f == 3'd5) && a[0]) bad = 1'b1;
        if (f == 3'd2 && a[1:0] != 2'd0) bad = 1'b1;
        if ((a >> 2) >= 32'd1024) bad = 1'b1;
        if (wr && (f == 3'd4 || f == 3'd5)) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f, input logic [1:0] off);
        logic [31:0] v;
        int sh;
        sh = 8 * int'(off);
        v = w;
        if (f == 3'd0 || f == 3'd4) begin
            v = (w >> sh) & 32'hFF;
            if (f == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (f == 3'd1 || f == 3'd5) begin
            v = (w >> sh) & 32'hFFFF;
            if (f == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [2:0] f, input logic [1:0] off, input logic [31:0] d);
        logic [31:0] mask;
        int sh;
        sh = 8 * int'(off);
        mask = (f == 3'd0) ? 32'hFF : 32'hFFFF;
        return (w & ~(mask << sh)) | ((d & mask) << sh);
    endfunction

    // Reference model: predicts registered outputs for the next cycle and
    // checks combinational memory-side outputs in the current cycle.
    int          m_busy = 0;
    int          m_idx = 0;
    logic [31:0] m_word = 32'h0;
    logic        m_rv = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic        m_fault = 1'b0;

    always @(negedge clock) begin
        logic        exp_wr;
        logic        nrv;
        logic        flt;
        int          exp_idx;
        logic [31:0] exp_wd;
        int          widx;
        if (mem_write) begin
            wr_count++;
            last_wr_idx = int'(mem_address);
        end
        if (reset) begin
            chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
            chk("rst_rdata", rdata, 32'h0);
            chk("rst_fault", {31'h0, fault}, 32'h0);
            chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
            chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
            m_busy = 0;
            m_rv = 1'b0;
            m_rdata = 32'h0;
            m_fault = 1'b0;
        end else begin
            chk("req_ready", {31'h0, req_ready}, {31'h0, m_busy == 0});
            chk("resp_valid", {31'h0, resp_valid}, {31'h0, m_rv});
            chk("rdata", rdata, m_rdata);
            chk("fault", {31'h0, fault}, {31'h0, m_fault});
            exp_wr = 1'b0;
            exp_idx = 0;
            exp_wd = 32'h0;
            nrv = 1'b0;
            if (m_busy != 0) begin
                exp_wr = 1'b1;
                exp_idx = m_idx;
                exp_wd = m_word;
                ref_mem[m_idx] = m_word;
                m_busy = 0;
                nrv = 1'b1;
                m_rdata = 32'h0;
                m_fault = 1'b0;
            end else if (req_valid) begin
                chk("mem_address_idle", mem_address, addr >> 2);
                flt = model_fault(req_write, funct3, addr);
                widx = int'(addr >> 2);
                nrv = 1'b1;
                if (flt) begin
                    m_rdata = 32'h0;
                    m_fault = 1'b1;
                end else if (!req_write) begin
                    m_rdata = model_load(ref_mem[widx], funct3, addr[1:0]);
                    m_fault = 1'b0;
                end else if (funct3 == 3'd2) begin
                    exp_wr = 1'b1;
                    exp_idx = widx;
                    exp_wd = wdata;
                    ref_mem[widx] = wdata;
                    m_rdata = 32'h0;
                    m_fault = 1'b0;
                end else begin
                    nrv = 1'b0;
                    m_busy = 1;
                    m_idx = widx;
                    m_word = model_merge(ref_mem[widx], funct3, addr[1:0], wdata);
                end
            end
            chk("mem_write", {31'h0, mem_write}, {31'h0, exp_wr});
            if (exp_wr) begin
                chk("mem_address_wr", mem_address, 32'(exp_idx));
                chk("mem_wdata", mem_wdata, exp_wd);
            end
            m_rv = nrv;
        end
    end

    // Issue one access (called just after a rising edge) and wait for its response.
    task automatic do_req(input logic wr, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                          output int lat, output logic ready_after);
        int stall;
        req_valid = 1'b1;
        req_write = wr;
        funct3 = f;
        addr = a;
        wdata = wd;
        stall = 0;
        while (!req_ready && stall < 8) begin
            @(posedge clock); #1;
            stall++;
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
        ready_after = req_ready;
        lat = 0;
        rd = 32'h0;
        flt = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            if (resp_valid) begin
                lat = n;
                rd = rdata;
                flt = fault;
                break;
            end
            @(posedge clock); #1;
        end
        $display("txn wr=%0d f3=%0d addr=%h wdata=%h -> rdata=%h fault=%0d lat=%0d",
                 wr, f, a, wd, rd, flt, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        flt;
        logic        rdy;
        int          lat;
        int          wc;
        logic [31:0] b2b_addr [4];
        logic        b2b_wr   [4];
        logic [31:0] b2b_wd   [4];
        logic [31:0] b2b_exp  [4];

        for (int i = 0; i < 1024; i++) begin
            tb_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        reset = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        funct3 = 3'd0;
        addr = 32'h0;
        wdata = 32'h0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk("ready_after_reset", {31'h0, req_ready}, 32'h1);

        // SW then LW at word 4
        wc = wr_count;
        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, flt, lat, rdy);
        chk("sw_lat", 32'(lat), 32'd1);
        chk("sw_rdata", rd, 32'h0);
        chk("sw_wr_count", 32'(wr_count - wc), 32'd1);
        chk("sw_wr_idx", 32'(last_wr_idx), 32'd4);
        chk("sw_mem", tb_mem[4], 32'hDEADBEEF);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, rd, flt, lat, rdy);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_fault", {31'h0, flt}, 32'h0);
        chk("lw_lat", 32'(lat), 32'd1);

        // SB into lane 1 via read-modify-write
        do_req(1'b1, 3'd0, 32'h11, 32'h55, rd, flt, lat, rdy);
        chk("sb_ready_low", {31'h0, rdy}, 32'h0);
        chk("sb_lat", 32'(lat), 32'd2);
        chk("sb_ready_back", {31'h0, req_ready}, 32'h1);
        chk("sb_mem", tb_mem[4], 32'hDEAD55EF);

        // sub-word loads
        do_req(1'b0, 3'd0, 32'h13, 32'h0, rd, flt, lat, rdy);
        chk("lb_13", rd, 32'hFFFFFFDE);
        do_req(1'b0, 3'd4, 32'h13, 32'h0, rd, flt, lat, rdy);
        chk("lbu_13", rd, 32'h000000DE);
        do_req(1'b0, 3'd1, 32'h12, 32'h0, rd, flt, lat, rdy);
        chk("lh_12", rd, 32'hFFFFDEAD);
        do_req(1'b0, 3'd5, 32'h10, 32'h0, rd, flt, lat, rdy);
        chk("lhu_10", rd, 32'h000055EF);

        // faulting accesses
        wc = wr_count;
        do_req(1'b0, 3'd2, 32'h12, 32'h0, rd, flt, lat, rdy);
        chk("lw12_fault", {31'h0, flt}, 32'h1);
        chk("lw12_rdata", rd, 32'h0);
        do_req(1'b1, 3'd1, 32'h13, 32'h1234, rd, flt, lat, rdy);
        chk("sh13_fault", {31'h0, flt}, 32'h1);
        chk("sh13_lat", 32'(lat), 32'd1);
        do_req(1'b1, 3'd2, 32'd4096, 32'hCAFEF00D, rd, flt, lat, rdy);
        chk("sw4096_fault", {31'h0, flt}, 32'h1);
        chk("sw4096_rdata", rd, 32'h0);
        do_req(1'b0, 3'd3, 32'h10, 32'h0, rd, flt, lat, rdy);
        chk("ld_f3_011_fault", {31'h0, flt}, 32'h1);
        do_req(1'b1, 3'd4, 32'h10, 32'h77, rd, flt, lat, rdy);
        chk("sbu_fault", {31'h0, flt}, 32'h1);
        chk("fault_no_write", 32'(wr_count - wc), 32'd0);
        chk("fault_mem", tb_mem[4], 32'hDEAD55EF);

        // SB abandoned by reset during RMW
        wc = wr_count;
        req_valid = 1'b1;
        req_write = 1'b1;
        funct3 = 3'd0;
        addr = 32'h10;
        wdata = 32'hAA;
        @(posedge clock); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("rmw_rst_ready", {31'h0, req_ready}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            chk("rmw_rst_no_resp", {31'h0, resp_valid}, 32'h0);
            @(posedge clock); #1;
        end
        chk("rmw_rst_no_write", 32'(wr_count - wc), 32'd0);
        chk("rmw_rst_mem", tb_mem[4], 32'hDEAD55EF);
        $display("txn sb addr=00000010 abandoned by reset, word4=%h", tb_mem[4]);

        // back-to-back LW, LW, SW, LW
        b2b_addr[0] = 32'h10; b2b_wr[0] = 1'b0; b2b_wd[0] = 32'h0;        b2b_exp[0] = 32'hDEAD55EF;
        b2b_addr[1] = 32'h14; b2b_wr[1] = 1'b0; b2b_wd[1] = 32'h0;        b2b_exp[1] = 32'h0;
        b2b_addr[2] = 32'h14; b2b_wr[2] = 1'b1; b2b_wd[2] = 32'h12345678; b2b_exp[2] = 32'h0;
        b2b_addr[3] = 32'h14; b2b_wr[3] = 1'b0; b2b_wd[3] = 32'h0;        b2b_exp[3] = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            chk("b2b_ready", {31'h0, req_ready}, 32'h1);
            req_valid = 1'b1;
            req_write = b2b_wr[i];
            funct3 = 3'd2;
            addr = b2b_addr[i];
            wdata = b2b_wd[i];
            @(posedge clock); #1;
            chk("b2b_resp_valid", {31'h0, resp_valid}, 32'h1);
            chk("b2b_rdata", rdata, b2b_exp[i]);
            $display("txn b2b[%0d] wr=%0d addr=%h -> resp_valid=%0d rdata=%h",
                     i, b2b_wr[i], b2b_addr[i], resp_valid, rdata);
        end
        req_valid = 1'b0;
        @(posedge clock); #1;
        chk("b2b_idle", {31'h0, resp_valid}, 32'h0);
        chk("b2b_mem", tb_mem[5], 32'h12345678);

        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
